// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: states, opcodes,
// datapath mux selects and the control word passed from decoder to top.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2,
    ALU_IMM   = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_B       = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_RSVD   = 2'd3
  } pc_source_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    pc_source_t pc_source;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: op_legal = 1'b1;
      default:                          op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Purely combinational decode of current state (plus opcode and memory
// readiness) into the datapath control word.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_rdy,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_rdy;
        ctrl.pc_write  = mem_rdy;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
        if (!op_legal(opcode)) begin
          ctrl.illegal_op = 1'b1;
          ctrl.instr_done = 1'b1;
        end
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_rdy;
      end
      R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_ne     = (opcode == OP_BNE);
        ctrl.instr_done    = 1'b1;
      end
      JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_IMM;
      end
      I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: state register and next-state logic;
// control decode lives in mc_ctrl_decode.
module multicycle_control_fsm #(
  parameter int unsigned STATE_W     = 4,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic               instr_done,
  output logic [STATE_W-1:0] state_dbg
);
  import mc_ctrl_pkg::*;

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;
  logic   mem_rdy;

  assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_comb begin
    state_next = state;
    case (state)
      FETCH:     if (mem_rdy) state_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:                         state_next = R_EXEC;
          OP_LW, OP_SW:                     state_next = MEM_ADDR;
          OP_BEQ, OP_BNE:                   state_next = BRANCH;
          OP_J:                             state_next = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_next = I_EXEC;
          default:                          state_next = FETCH;
        endcase
      end
      MEM_ADDR:  state_next = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (mem_rdy) state_next = MEM_WB;
      MEM_WRITE: if (mem_rdy) state_next = FETCH;
      R_EXEC:    state_next = R_WB;
      I_EXEC:    state_next = I_WB;
      default:   state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  mc_ctrl_decode u_decode (
    .state   (state),
    .opcode  (opcode),
    .mem_rdy (mem_rdy),
    .ctrl    (ctrl)
  );

  // Strobes are gated directly by the async reset so a reset landing
  // mid-access kills any write in the same instant, not at the next edge.
  assign pc_write      = ctrl.pc_write      & reset;
  assign pc_write_cond = ctrl.pc_write_cond & reset;
  assign ir_write      = ctrl.ir_write      & reset;
  assign reg_write     = ctrl.reg_write     & reset;
  assign mem_read      = ctrl.mem_read      & reset;
  assign mem_write     = ctrl.mem_write     & reset;
  assign illegal_op    = ctrl.illegal_op    & reset;
  assign instr_done    = ctrl.instr_done    & reset;

  assign branch_ne  = ctrl.branch_ne;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_dst    = ctrl.reg_dst;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign state_dbg  = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: per-cycle expected control words are queued by the stimulus
// and compared by an independent monitor on the falling edge.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       ill, done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, opcode0;
  logic       mem_ready, mem_ready0;

  always #5 clk = ~clk;

  logic       pc_write1, pc_write_cond1, branch_ne1, i_or_d1, mem_read1, mem_write1;
  logic       ir_write1, mem_to_reg1, reg_dst1, reg_write1, alu_src_a1, illegal_op1, instr_done1;
  logic [1:0] alu_src_b1, alu_op1, pc_source1;
  logic [3:0] state_dbg1;

  logic       pc_write0, pc_write_cond0, branch_ne0, i_or_d0, mem_read0, mem_write0;
  logic       ir_write0, mem_to_reg0, reg_dst0, reg_write0, alu_src_a0, illegal_op0, instr_done0;
  logic [1:0] alu_src_b0, alu_op0, pc_source0;
  logic [3:0] state_dbg0;

  multicycle_control_fsm #(.STATE_W(4), .MEM_WAIT_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write1), .pc_write_cond(pc_write_cond1), .branch_ne(branch_ne1),
    .i_or_d(i_or_d1), .mem_read(mem_read1), .mem_write(mem_write1), .ir_write(ir_write1),
    .mem_to_reg(mem_to_reg1), .reg_dst(reg_dst1), .reg_write(reg_write1),
    .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_op(alu_op1),
    .pc_source(pc_source1), .illegal_op(illegal_op1), .instr_done(instr_done1),
    .state_dbg(state_dbg1)
  );

  multicycle_control_fsm #(.STATE_W(4), .MEM_WAIT_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode0), .mem_ready(mem_ready0),
    .pc_write(pc_write0), .pc_write_cond(pc_write_cond0), .branch_ne(branch_ne0),
    .i_or_d(i_or_d0), .mem_read(mem_read0), .mem_write(mem_write0), .ir_write(ir_write0),
    .mem_to_reg(mem_to_reg0), .reg_dst(reg_dst0), .reg_write(reg_write0),
    .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_op(alu_op0),
    .pc_source(pc_source0), .illegal_op(illegal_op0), .instr_done(instr_done0),
    .state_dbg(state_dbg0)
  );

  exp_t act1, act0;
  assign act1 = {state_dbg1, pc_write1, pc_write_cond1, branch_ne1, i_or_d1, mem_read1,
                 mem_write1, ir_write1, mem_to_reg1, reg_dst1, reg_write1, alu_src_a1,
                 alu_src_b1, alu_op1, pc_source1, illegal_op1, instr_done1};
  assign act0 = {state_dbg0, pc_write0, pc_write_cond0, branch_ne0, i_or_d0, mem_read0,
                 mem_write0, ir_write0, mem_to_reg0, reg_dst0, reg_write0, alu_src_a0,
                 alu_src_b0, alu_op0, pc_source0, illegal_op0, instr_done0};

  // Hand-derived expected control words, one per state/condition
  exp_t E_RST, F_RDY, F_WAIT, DEC, DEC_ILL, MADDR, MRD, MWB, MWR_WAIT, MWR_DONE;
  exp_t REX, RWB, BNE, BEQ, JMP, IEX, IWB;

  exp_t q1[$], q0[$];
  int   n1[$], n0[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step(input bit sel, input logic rst, input logic [5:0] op,
                      input logic rdy, input exp_t e, input int id);
    @(posedge clk);
    #1;
    reset = rst;
    if (sel) begin
      opcode = op; mem_ready = rdy;
      q1.push_back(e); n1.push_back(id);
    end else begin
      opcode0 = op; mem_ready0 = rdy;
      q0.push_back(e); n0.push_back(id);
    end
  endtask

  initial begin
    exp_t e; int id;
    forever begin
      @(negedge clk);
      if (q1.size() > 0) begin
        e = q1.pop_front(); id = n1.pop_front();
        checks++;
        if (act1 !== e) begin
          errors++;
          $display("FAIL wait_en1 step %0d: got %h expected %h", id, act1, e);
        end
      end
      if (q0.size() > 0) begin
        e = q0.pop_front(); id = n0.pop_front();
        checks++;
        if (act0 !== e) begin
          errors++;
          $display("FAIL wait_en0 step %0d: got %h expected %h", id, act0, e);
        end
      end
    end
  end

  initial begin
    E_RST = '0;    E_RST.srcb = 2'd1;
    F_WAIT = '0;   F_WAIT.mrd = 1'b1; F_WAIT.srcb = 2'd1;
    F_RDY = F_WAIT; F_RDY.irw = 1'b1; F_RDY.pcw = 1'b1;
    DEC = '0;      DEC.st = 4'd1; DEC.srcb = 2'd3;
    DEC_ILL = DEC; DEC_ILL.ill = 1'b1; DEC_ILL.done = 1'b1;
    MADDR = '0;    MADDR.st = 4'd2; MADDR.srca = 1'b1; MADDR.srcb = 2'd2;
    MRD = '0;      MRD.st = 4'd3; MRD.mrd = 1'b1; MRD.iord = 1'b1;
    MWB = '0;      MWB.st = 4'd4; MWB.rw = 1'b1; MWB.m2r = 1'b1; MWB.done = 1'b1;
    MWR_WAIT = '0; MWR_WAIT.st = 4'd5; MWR_WAIT.mwr = 1'b1; MWR_WAIT.iord = 1'b1;
    MWR_DONE = MWR_WAIT; MWR_DONE.done = 1'b1;
    REX = '0;      REX.st = 4'd6; REX.srca = 1'b1; REX.aluop = 2'd2;
    RWB = '0;      RWB.st = 4'd7; RWB.rw = 1'b1; RWB.rdst = 1'b1; RWB.done = 1'b1;
    BEQ = '0;      BEQ.st = 4'd8; BEQ.srca = 1'b1; BEQ.aluop = 2'd1; BEQ.pcwc = 1'b1;
                   BEQ.pcsrc = 2'd1; BEQ.done = 1'b1;
    BNE = BEQ;     BNE.bne = 1'b1;
    JMP = '0;      JMP.st = 4'd9; JMP.pcw = 1'b1; JMP.pcsrc = 2'd2; JMP.done = 1'b1;
    IEX = '0;      IEX.st = 4'd10; IEX.srca = 1'b1; IEX.srcb = 2'd2; IEX.aluop = 2'd3;
    IWB = '0;      IWB.st = 4'd11; IWB.rw = 1'b1; IWB.done = 1'b1;

    reset = 1'b0; opcode = 6'h00; mem_ready = 1'b1;
    opcode0 = 6'h2B; mem_ready0 = 1'b0;

    // reset, then sw interrupted by reset while waiting in MEM_WRITE
    step(1, 0, 6'h00, 1, E_RST, 0);
    step(1, 0, 6'h00, 1, E_RST, 1);
    step(1, 1, 6'h2B, 1, F_RDY, 2);
    step(1, 1, 6'h2B, 1, DEC, 3);
    step(1, 1, 6'h2B, 1, MADDR, 4);
    step(1, 1, 6'h2B, 0, MWR_WAIT, 5);
    step(1, 1, 6'h2B, 0, MWR_WAIT, 6);
    step(1, 0, 6'h2B, 0, E_RST, 7);
    step(1, 0, 6'h2B, 1, E_RST, 8);
    step(1, 1, 6'h00, 1, F_RDY, 9);
    // R-type; opcode scrambled after DECODE must be ignored
    step(1, 1, 6'h00, 1, DEC, 10);
    step(1, 1, 6'h3F, 1, REX, 11);
    step(1, 1, 6'h3F, 1, RWB, 12);
    // lw: 2 fetch waits, 3 memory waits -> 10 cycles
    step(1, 1, 6'h23, 0, F_WAIT, 13);
    step(1, 1, 6'h23, 0, F_WAIT, 14);
    step(1, 1, 6'h23, 1, F_RDY, 15);
    step(1, 1, 6'h23, 1, DEC, 16);
    step(1, 1, 6'h23, 0, MADDR, 17);
    step(1, 1, 6'h23, 0, MRD, 18);
    step(1, 1, 6'h23, 0, MRD, 19);
    step(1, 1, 6'h23, 0, MRD, 20);
    step(1, 1, 6'h23, 1, MRD, 21);
    step(1, 1, 6'h23, 1, MWB, 22);
    // bne, beq, j
    step(1, 1, 6'h05, 1, F_RDY, 23);
    step(1, 1, 6'h05, 1, DEC, 24);
    step(1, 1, 6'h05, 1, BNE, 25);
    step(1, 1, 6'h04, 1, F_RDY, 26);
    step(1, 1, 6'h04, 1, DEC, 27);
    step(1, 1, 6'h04, 1, BEQ, 28);
    step(1, 1, 6'h02, 1, F_RDY, 29);
    step(1, 1, 6'h02, 1, DEC, 30);
    step(1, 1, 6'h02, 1, JMP, 31);
    // ori, opcode changed during I_EXEC
    step(1, 1, 6'h0D, 1, F_RDY, 32);
    step(1, 1, 6'h0D, 1, DEC, 33);
    step(1, 1, 6'h3F, 1, IEX, 34);
    step(1, 1, 6'h3F, 1, IWB, 35);
    // illegal opcode returns straight to FETCH
    step(1, 1, 6'h3F, 1, F_RDY, 36);
    step(1, 1, 6'h3F, 1, DEC_ILL, 37);
    step(1, 1, 6'h00, 1, F_RDY, 38);

    // MEM_WAIT_EN=0 instance, mem_ready held low: sw in 4 cycles
    step(0, 0, 6'h2B, 0, E_RST, 100);
    step(0, 1, 6'h2B, 0, F_RDY, 101);
    step(0, 1, 6'h2B, 0, DEC, 102);
    step(0, 1, 6'h2B, 0, MADDR, 103);
    step(0, 1, 6'h2B, 0, MWR_DONE, 104);
    step(0, 1, 6'h2B, 0, F_RDY, 105);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (q1.size() != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending %0d/%0d expected 0/0", q1.size(), q0.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
